// File: rtl/prewish_mask_arbiter.sv
// Round-robin arbiter that collects edge-triggered byte requests from four
// requesters and issues them one at a time as downstream mask writes,
// with a configurable number of idle cycles after every strobe.
module prewish_mask_arbiter #(
  parameter int unsigned GAP = 2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [3:0]  REQ_STB_I,
  input  logic [31:0] REQ_DAT_I,
  output logic [3:0]  REQ_ACK_O,
  output logic        STB_O,
  output logic [7:0]  DAT_O,
  output logic [1:0]  GNT_O,
  output logic [3:0]  PEND_O,
  output logic        o_alive
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned IW   = 2;
  localparam int unsigned CW   = 4;
  localparam logic [CW-1:0] GAP_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] stb_q;
  logic [NREQ-1:0] pend_q;
  logic [NREQ-1:0] pend_d;
  logic [DW-1:0]   slot_q [NREQ];
  logic [NREQ-1:0] ack_q;
  logic            strobe_q;
  logic [DW-1:0]   dat_q;
  logic [IW-1:0]   gnt_q;
  logic            alive_q;
  logic [CW-1:0]   cnt_q;

  logic [NREQ-1:0] edge_c;
  logic [NREQ-1:0] clr_c;
  logic [IW-1:0]   win_c;
  logic [IW-1:0]   cand_c;
  logic            hit_c;

  assign REQ_ACK_O = ack_q;
  assign STB_O     = strobe_q;
  assign DAT_O     = dat_q;
  assign GNT_O     = gnt_q;
  assign PEND_O    = pend_q;
  assign o_alive   = alive_q;

  // Rising-edge request detection and pending-flag next state; a fresh edge
  // on the requester being issued keeps its flag set.
  always_comb begin
    edge_c = REQ_STB_I & ~stb_q;
    clr_c  = '0;
    if (state_q == ST_ISSUE) begin
      clr_c = NREQ'(1) << gnt_q;
    end
    pend_d = (pend_q & ~clr_c) | edge_c;
  end

  // Round-robin winner search starting just after the last grant.
  always_comb begin
    win_c  = gnt_q;
    cand_c = gnt_q;
    hit_c  = 1'b0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      cand_c = gnt_q + IW'(i);
      if (!hit_c && pend_q[cand_c]) begin
        win_c = cand_c;
        hit_c = 1'b1;
      end
    end
  end

  // Request capture, arbitration FSM and registered outputs.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= ST_IDLE;
      stb_q    <= '0;
      pend_q   <= '0;
      ack_q    <= '0;
      strobe_q <= 1'b0;
      dat_q    <= '0;
      gnt_q    <= IW'(3);
      alive_q  <= 1'b1;
      cnt_q    <= '0;
      for (int k = 0; k < int'(NREQ); k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      stb_q    <= REQ_STB_I;
      pend_q   <= pend_d;
      strobe_q <= 1'b0;
      ack_q    <= '0;
      for (int k = 0; k < int'(NREQ); k++) begin
        if (edge_c[k]) begin
          slot_q[k] <= REQ_DAT_I[DW*k +: DW];
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (pend_q != '0) begin
            dat_q    <= slot_q[win_c];
            gnt_q    <= win_c;
            strobe_q <= 1'b1;
            ack_q    <= NREQ'(1) << win_c;
            alive_q  <= ~alive_q;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (GAP > 0) begin
            cnt_q   <= GAP_LOAD;
            state_q <= ST_GAP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/prewish_mask_arbiter.md
PREWISH_MASK_ARBITER -- requirements
Module: prewish_mask_arbiter

Interface
REQ-001 SHALL have parameter GAP, default 2, meaning idle cycles forced after each downstream strobe (range 0-15).
REQ-002 SHALL have port CLK_I  input  1  the single system clock; all logic on its rising edge.
REQ-003 SHALL have port RST_I  input  1  synchronous, active-high reset.
REQ-004 SHALL have port REQ_STB_I  input  4  per-requester write strobe; bit k belongs to requester k.
REQ-005 SHALL have port REQ_DAT_I  input  32  packed requester data; requester k at bits [8k+7:8k].
REQ-006 SHALL have port REQ_ACK_O  output  4  one-cycle pulse on bit k when requester k's data is issued downstream.
REQ-007 SHALL have port STB_O  output  1  downstream mask-write strobe, one cycle per issue.
REQ-008 SHALL have port DAT_O  output  8  downstream mask data.
REQ-009 SHALL have port GNT_O  output  2  index of the most recently issued requester.
REQ-010 SHALL have port PEND_O  output  4  current pending flags, one per requester.
REQ-011 SHALL have port o_alive  output  1  debug LED; toggles on every issue.

Function
REQ-012 SHALL register REQ_STB_I each cycle and detect a request on bit k only on a 0->1 transition (current=1, registered=0).
REQ-013 SHALL, on a detected edge for k, capture REQ_DAT_I[8k+7:8k] into slot k and set pending[k] at that same clock edge.
REQ-014 SHALL, on a new edge for k while pending[k]=1, overwrite slot k (latest data wins), keep pending[k]=1, and produce no extra ACK.
REQ-015 SHALL implement states IDLE, ISSUE, GAP; no other reachable states; any illegal encoding returns to IDLE next cycle with STB_O=0.
REQ-016 IDLE: if PEND_O!=0, SHALL select winner w round-robin starting at (GNT_O+1) mod 4, load DAT_O<=slot[w], GNT_O<=w, go to ISSUE; else stay.
REQ-017 ISSUE: SHALL drive STB_O=1 and REQ_ACK_O[w]=1 for exactly this one cycle, clear pending[w], toggle o_alive; next state GAP if GAP>0, else IDLE.
REQ-018 GAP: SHALL hold STB_O=0 for exactly GAP cycles via a down-counter, then go to IDLE.
REQ-019 SHALL keep DAT_O stable from entry to ISSUE until the next ISSUE entry.
REQ-020 Latency: edge detected at clock edge t with arbiter IDLE -> STB_O high in the cycle following edge t+1.
REQ-021 SHALL space STB_O assertions by at least GAP+2 cycles (ISSUE + GAP + one IDLE cycle).
REQ-022 Simultaneous new edge on w during its ISSUE cycle: ACK still pulses, slot w takes the new data, pending[w] remains 1.
REQ-023 Simultaneous edges on several requesters: all set pending in the same cycle; service order is strict round-robin per REQ-016.
REQ-024 SHALL give no requester a second issue while another requester has been pending since before that requester's previous issue (no starvation).

Reset
REQ-025 While RST_I=1 at a clock edge: state<=IDLE, STB_O<=0, REQ_ACK_O<=0, DAT_O<=0, slots<=0, PEND_O<=0, GNT_O<=3, GAP counter<=0, registered REQ_STB_I<=0, o_alive<=1.
REQ-026 Reset SHALL dominate all other events, including mid-ISSUE or mid-GAP; pending requests are discarded.
REQ-027 A REQ_STB_I bit held high through reset release SHALL count as one edge on the first non-reset cycle.

Verification
REQ-028 Single request: after reset, pulse REQ_STB_I=0001 with data 0xB4 -> one STB_O cycle with DAT_O=0xB4, REQ_ACK_O=0001 in the same cycle, GNT_O=0, o_alive=0.
REQ-029 Simultaneous requests: REQ_STB_I 0000->1111 with data 0x11/0x22/0x33/0x44 -> STB_O issues 0x11,0x22,0x33,0x44 in order, spaced exactly GAP+2=4 cycles.
REQ-030 Round-robin fairness: requesters 0 and 2 re-request immediately after each ACK for 20 issues -> grants strictly alternate 0,2,0,2.
REQ-031 Overwrite: requester 1 edges 0x0F then 0xF0 while the arbiter is servicing 0 -> a single issue for requester 1 with DAT_O=0xF0 and one ACK.
REQ-032 Reset mid-operation: assert RST_I during ISSUE with 3 requests pending -> STB_O=0 next cycle, PEND_O=0, DAT_O=0, GNT_O=3; no strobe after release until a new edge.
REQ-033 GAP=0 build: two requesters pending -> STB_O pulses exactly 2 cycles apart.
